// File: rtl/i2c_master_arbiter_if.sv
// Requester and engine-command bundle for i2c_master_arbiter.
// slave is the arbiter's view; master is the requesters/engine side.
interface i2c_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic                      eng_start;
  logic                      eng_rw;
  logic [ADDR_W-1:0]         eng_addr;
  logic [DATA_W-1:0]         eng_wdata;
  logic                      eng_abort;
  logic                      eng_done;
  logic                      eng_nack;
  logic [DATA_W-1:0]         eng_rdata;

  modport slave (
    input  req, req_rw, req_addr, req_wdata, eng_done, eng_nack, eng_rdata,
    output gnt, done, rdata, err, eng_start, eng_rw, eng_addr, eng_wdata, eng_abort
  );

  modport master (
    output req, req_rw, req_addr, req_wdata, eng_done, eng_nack, eng_rdata,
    input  gnt, done, rdata, err, eng_start, eng_rw, eng_addr, eng_wdata, eng_abort
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between NUM_REQ requesters,
// one transaction in flight, with per-transaction timeout and abort.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  rst,
  i2c_master_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                eng_rw_q, eng_rw_d;
  logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
  logic [DATA_W-1:0]   eng_wdata_q, eng_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                abort_q, abort_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  int unsigned         probe;
  logic [NUM_REQ-1:0]  winner_oh;

  // First requesting index at or above rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    probe      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      probe = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!pick_valid && bus.req[IDX_W'(probe)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(probe);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    eng_rw_d    = eng_rw_q;
    eng_addr_d  = eng_addr_q;
    eng_wdata_d = eng_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    abort_d     = abort_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          winner_d    = pick_idx;
          eng_rw_d    = bus.req_rw[pick_idx];
          eng_addr_d  = bus.req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
          eng_wdata_d = bus.req_wdata[32'(pick_idx) * DATA_W +: DATA_W];
          state_d     = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion on the final timeout cycle takes priority over the abort.
        if (bus.eng_done) begin
          rdata_d = bus.eng_rdata;
          err_d   = bus.eng_nack;
          abort_d = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        abort_d  = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      cnt_q       <= '0;
      eng_rw_q    <= 1'b0;
      eng_addr_q  <= '0;
      eng_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      cnt_q       <= cnt_d;
      eng_rw_q    <= eng_rw_d;
      eng_addr_q  <= eng_addr_d;
      eng_wdata_q <= eng_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
    end
  end

  assign winner_oh     = NUM_REQ'(1) << winner_q;
  assign bus.gnt       = (state_q != StIdle) ? winner_oh : '0;
  assign bus.done      = (state_q == StResp) ? winner_oh : '0;
  assign bus.eng_start = (state_q == StStart);
  assign bus.eng_abort = (state_q == StResp) && abort_q;
  assign bus.eng_rw    = eng_rw_q;
  assign bus.eng_addr  = eng_addr_q;
  assign bus.eng_wdata = eng_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized self-checking bench for i2c_master_arbiter against a
// transaction-level model of arbitration order, latency and timeout.
module tb_i2c_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rr_model = 0;

  logic [AW-1:0] addr_tab  [N];
  logic [DW-1:0] wdata_tab [N];
  logic          rw_tab    [N];

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      int j = (ptr + i) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = addr_tab[i];
      bus.req_wdata[i*DW +: DW] = wdata_tab[i];
      bus.req_rw[i]             = rw_tab[i];
    end
  endtask

  task automatic random_ops();
    for (int i = 0; i < N; i++) begin
      addr_tab[i]  = AW'($urandom);
      wdata_tab[i] = DW'($urandom);
      rw_tab[i]    = 1'($urandom);
    end
    drive_ops();
  endtask

  // One transaction: engine completes done_k WAIT cycles in (<=0 or >TO: never).
  task automatic run_txn(input int idx, input int done_k, input logic nack,
                         input logic [DW-1:0] rd, input logic release_req,
                         input logic scramble, input logic drop_early);
    logic [N-1:0]  oh;
    logic          erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    logic          to;
    logic          seen;
    int            t;
    oh  = N'(1) << idx;
    erw = rw_tab[idx];
    ea  = addr_tab[idx];
    ew  = wdata_tab[idx];
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      seen = bus.eng_start;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL start_wait: eng_start never seen (got 0, required 1) for idx %0d", idx);
      return;
    end
    n_checks++;
    if ({bus.gnt, bus.done, bus.eng_rw, bus.eng_addr, bus.eng_wdata} !==
        {oh, {N{1'b0}}, erw, ea, ew}) begin
      n_fail++;
      $display("FAIL start_cycle: gnt=%b done=%b rw=%b addr=%h wdata=%h required %b 0 %b %h %h",
               bus.gnt, bus.done, bus.eng_rw, bus.eng_addr, bus.eng_wdata, oh, erw, ea, ew);
    end
    if (scramble) random_ops();
    if (drop_early) bus.req = '0;
    to      = (done_k <= 0 || done_k > TO);
    t       = to ? TO : done_k;
    exp_err = to ? 1'b1 : nack;
    exp_rd  = to ? '0 : rd;
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk);
      if (k <= t) begin
        n_checks++;
        if ({bus.gnt, bus.done, bus.eng_start, bus.eng_abort, bus.eng_rw, bus.eng_addr,
             bus.eng_wdata} !== {oh, {N{1'b0}}, 1'b0, 1'b0, erw, ea, ew}) begin
          n_fail++;
          $display("FAIL wait_k%0d: gnt=%b done=%b start=%b abort=%b ops=%b/%h/%h required %b 0 0 0 %b/%h/%h",
                   k, bus.gnt, bus.done, bus.eng_start, bus.eng_abort, bus.eng_rw,
                   bus.eng_addr, bus.eng_wdata, oh, erw, ea, ew);
        end
        bus.eng_done  = (k == done_k);
        bus.eng_nack  = (k == done_k) ? nack : 1'($urandom);
        bus.eng_rdata = (k == done_k) ? rd : DW'($urandom);
      end else begin
        n_checks++;
        if ({bus.done, bus.gnt, bus.err, bus.rdata, bus.eng_abort, bus.eng_start} !==
            {oh, oh, exp_err, exp_rd, to, 1'b0}) begin
          n_fail++;
          $display("FAIL resp idx%0d: done=%b gnt=%b err=%b rdata=%h abort=%b start=%b required %b %b %b %h %b 0",
                   idx, bus.done, bus.gnt, bus.err, bus.rdata, bus.eng_abort, bus.eng_start,
                   oh, oh, exp_err, exp_rd, to);
        end
        bus.eng_done = 1'b0;
        if (release_req) bus.req[idx] = 1'b0;
      end
    end
    rr_model = (idx + 1) % N;
    @(negedge clk);
    n_checks++;
    if ({bus.gnt, bus.done, bus.eng_start, bus.eng_abort, bus.err, bus.rdata} !==
        {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, exp_err, exp_rd}) begin
      n_fail++;
      $display("FAIL post_idle: gnt=%b done=%b start=%b abort=%b err=%b rdata=%h required 0 0 0 0 %b %h",
               bus.gnt, bus.done, bus.eng_start, bus.eng_abort, bus.err, bus.rdata,
               exp_err, exp_rd);
    end
    // Stray completion while idle must be ignored.
    bus.eng_done = 1'($urandom);
  endtask

  task automatic test_reset();
    bus.req = '1; bus.eng_done = 1'b0; bus.eng_nack = 1'b0; bus.eng_rdata = '0;
    random_ops();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({bus.gnt, bus.done, bus.rdata, bus.err, bus.eng_start, bus.eng_rw, bus.eng_addr,
           bus.eng_wdata, bus.eng_abort} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: gnt=%b done=%b start=%b addr=%h required all 0",
                 bus.gnt, bus.done, bus.eng_start, bus.eng_addr);
      end
    end
    bus.req = '0;
    rst = 1'b1;
    rr_model = 0;
  endtask

  task automatic test_single_write();
    addr_tab[0] = 8'd50; wdata_tab[0] = 8'd100; rw_tab[0] = 1'b0;
    drive_ops();
    bus.req[0] = 1'b1;
    run_txn(pick(bus.req, rr_model), 10, 1'b0, DW'($urandom), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    addr_tab[2] = 8'd20; rw_tab[2] = 1'b1;
    drive_ops();
    bus.req[2] = 1'b1;
    run_txn(pick(bus.req, rr_model), 5, 1'b0, 8'd120, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    random_ops();
    bus.req = 4'b1011;
    for (int n = 0; n < 6; n++)
      run_txn(pick(bus.req, rr_model), 3, 1'b0, DW'($urandom), 1'b0, 1'b1, 1'b0);
    bus.req = '0;
  endtask

  task automatic test_timeout();
    random_ops();
    bus.req[1] = 1'b1;
    run_txn(pick(bus.req, rr_model), 0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    bus.req[1] = 1'b1;
    run_txn(pick(bus.req, rr_model), 4, 1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    random_ops();
    bus.req[3] = 1'b1;
    run_txn(pick(bus.req, rr_model), TO, 1'($urandom), DW'($urandom), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      random_ops();
      bus.req = N'($urandom_range(1, (1 << N) - 1));
      run_txn(pick(bus.req, rr_model), int'($urandom_range(1, TO + 2)), 1'($urandom),
              DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    random_ops();
    bus.req = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      seen = bus.eng_start;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midreset_start: eng_start=0 required 1");
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1100;
    #1;
    n_checks++;
    if ({bus.gnt, bus.done, bus.rdata, bus.err, bus.eng_start, bus.eng_addr, bus.eng_wdata,
         bus.eng_rw, bus.eng_abort} !== '0) begin
      n_fail++;
      $display("FAIL midreset_immediate: gnt=%b done=%b addr=%h required all 0",
               bus.gnt, bus.done, bus.eng_addr);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({bus.done, bus.gnt, bus.eng_abort} !== '0) begin
        n_fail++;
        $display("FAIL midreset_hold: done=%b gnt=%b abort=%b required 0", bus.done, bus.gnt,
                 bus.eng_abort);
      end
    end
    rr_model = 0;
    rst = 1'b1;
    n_checks++;
    if (pick(bus.req, rr_model) != 2) begin
      n_fail++;
      $display("FAIL midreset_model: winner %0d required 2", pick(bus.req, rr_model));
    end
    run_txn(2, 2, 1'b0, DW'($urandom), 1'b1, 1'b0, 1'b0);
    bus.req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_collision();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
Shares the single I2C master engine of the memory subsystem between NUM_REQ requesters, e.g. host, self-test and config loader, each of which issues read/write transactions to the memory controller slave. Round-robin arbitration, operand capture, one transaction in flight, per-transaction timeout and error reporting. Sits between the requesters and the I2C master engine's start/done command port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, slave/memory address width
DATA_W, 8, data byte width
TIMEOUT_CYC, 1024, max clk cycles in WAIT before abort (>=4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, held high until its done pulse
req_rw  in  NUM_REQ  per-requester direction: 1=read, 0=write
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
gnt  out  NUM_REQ  one-hot grant; high from START through RESP
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  out  DATA_W  read data; valid in the done cycle
err  out  1  error flag; valid in the done cycle (NACK or timeout)
eng_start  out  1  one-cycle start pulse to the I2C engine
eng_rw  out  1  latched direction
eng_addr  out  ADDR_W  latched address
eng_wdata  out  DATA_W  latched write data
eng_abort  out  1  one-cycle abort pulse on timeout
eng_done  in  1  engine transaction complete, one-cycle pulse
eng_nack  in  1  slave NACK; qualified by eng_done
eng_rdata  in  DATA_W  engine read data; qualified by eng_done

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0. Reset mid-transaction drops everything. No done is issued. The engine sees no abort. The system resets the engine on the same rst.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any req bit is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ. Latch the winner's rw/addr/wdata into eng_* registers. Go to START. If no req is set, stay in IDLE.
- START, one cycle: gnt[winner]=1 and eng_start=1. Go to WAIT and clear the counter.
- WAIT: gnt stays high and the counter increments each cycle.
  - On eng_done: capture eng_rdata into rdata, set err=eng_nack, go to RESP.
  - Else, if counter == TIMEOUT_CYC-1: set err=1, rdata=0, assert eng_abort for the RESP cycle, go to RESP.
  - If eng_done arrives in the same cycle as the timeout, eng_done wins and there is no abort.
- RESP, one cycle: done[winner]=1, rdata/err valid, gnt still high. Set rr_ptr=(winner+1) mod NUM_REQ. Go to IDLE.
- In the next cycle gnt=0 and done=0. rdata/err hold until the next RESP.
- Latency: req sampled high in IDLE at edge k gives eng_start at k+1. eng_done sampled at edge d gives done at d+1. There is a minimum 1-cycle IDLE gap between transactions.
- eng_* operand outputs are stable from START until the next IDLE capture. Requester operand changes after capture are ignored.
- A requester dropping req mid-transaction does not cancel it. done still pulses to that index.
- eng_done in IDLE, START or RESP is ignored.
- gnt and done are never multi-hot. At most one eng_start per transaction.

Test Plan:
- Single write: reset, release rst; req[0]=1, rw=0, addr=8'd50, wdata=8'd100. Expected: eng_start 1 cycle later with eng_addr=50, eng_wdata=100. Engine returns eng_done 10 cycles later with nack=0. Expected: done[0] pulses the next cycle with err=0, and gnt[0] drops a cycle after that.
- Read: req[2]=1, rw=1, addr=8'd20; engine returns eng_rdata=8'd120. Expected: rdata=120 and err=0 in the done[2] cycle.
- Round-robin: req=4'b1011 held continuously, each transaction completing after 3 cycles. Expected: grant order 0,1,3,0,1,3; requester 2 never granted.
- Timeout: req[1] with TIMEOUT_CYC=16 and eng_done never asserted. Expected: eng_abort and done[1] exactly 16 cycles after WAIT entry, err=1, rdata=0. Then req[1] with nack=1: err=1, no abort.
- Collision: eng_done asserted on the last timeout cycle. Expected: err=eng_nack and eng_abort stays 0.
- Reset mid-operation: assert rst=0 during WAIT. Expected: all outputs 0 immediately, no done pulse. After release, req=4'b1100 is granted to index 2 first, since rr_ptr=0 searches upward.
